// File: rtl/hazard_unit_mc_if.sv
// Hazard unit interface: groups the pipeline-register indices and control bits the
// hazard unit observes, plus the stall/flush/forward controls it drives.
//   slave  modport: hazard unit side (observes pipeline state, drives controls)
//   master modport: core datapath/controller side (drives pipeline state, observes controls)
// Signals:
//   Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  register indices (REGW bits)
//   RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdStartE  pipeline status bits
//   StallF, StallD, StallE, FlushD, FlushE, FlushM      pipeline register controls
//   ForwardAE, ForwardBE                                 E operand forward selects
//   MdBusy                                               multi-cycle op occupying E
interface hazard_unit_mc_if #(
    parameter int unsigned REGW = 5
);
    logic [REGW-1:0] Rs1D;
    logic [REGW-1:0] Rs2D;
    logic [REGW-1:0] Rs1E;
    logic [REGW-1:0] Rs2E;
    logic [REGW-1:0] RdE;
    logic [REGW-1:0] RdM;
    logic [REGW-1:0] RdW;
    logic            RegWriteM;
    logic            RegWriteW;
    logic            ResultSrcE0;
    logic            PCSrcE;
    logic            MdStartE;
    logic            StallF;
    logic            StallD;
    logic            StallE;
    logic            FlushD;
    logic            FlushE;
    logic            FlushM;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic            MdBusy;

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdStartE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output ForwardAE, ForwardBE, MdBusy
    );

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdStartE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  ForwardAE, ForwardBE, MdBusy
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard unit for a 5-stage (F/D/E/M/W) RISC-V pipeline.
// Provides M/W operand forwarding, load-use stall, branch/jump flush and a busy
// counter that holds a MUL/DIV op in E for MD_LAT cycles.
// Ports:
//   clk    core clock
//   reset  synchronous, active-high reset
//   hz     hazard_unit_mc_if.slave (pipeline state in, stall/flush/forward out)
//   LdStallCnt, BrFlushCnt, MdStallCnt  saturating perf counters (PERF_W bits),
//          present only when the macro HAZARD_PERF_EN is defined.
// All outputs are combinational from inputs and state; state updates on posedge clk.
module hazard_unit_mc #(
    parameter int unsigned REGW   = 5,
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned PERF_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_unit_mc_if.slave    hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]  LdStallCnt,
    output logic [PERF_W-1:0]  BrFlushCnt,
    output logic [PERF_W-1:0]  MdStallCnt
`endif
);
    localparam int unsigned CNTW     = $clog2(MD_LAT + 1);
    localparam bit          MD_MULTI = (MD_LAT > 1);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } md_state_e;

    md_state_e       state;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            md_arm_q, md_arm_d;
    logic            lw_stall;
    logic            md_launch;
    logic            md_busy;

    // M stage result beats W stage result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REGW-1:0] rs,
        input logic [REGW-1:0] rd_m,
        input logic [REGW-1:0] rd_w,
        input logic            wr_m,
        input logic            wr_w
    );
        if ((rs != '0) && (rs == rd_m) && wr_m) begin
            return 2'b10;
        end else if ((rs != '0) && (rs == rd_w) && wr_w) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        lw_stall  = hz.ResultSrcE0 && (hz.RdE != '0) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
        // md_arm_q blocks the op that just finished from launching again while it
        // is still sitting in E waiting to advance.
        md_launch = MD_MULTI && hz.MdStartE && (cnt_q == '0) && !md_arm_q;
        md_busy   = (cnt_q != '0) || md_launch;
        state     = (cnt_q != '0) ? StBusy : StIdle;
    end

    // Next-state logic for the busy counter and re-launch guard.
    always_comb begin
        cnt_d    = cnt_q;
        md_arm_d = md_arm_q;
        unique case (state)
            StIdle: begin
                if (md_launch) begin
                    cnt_d = CNTW'(MD_LAT - 1);
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CNTW'(1);
            end
            default: cnt_d = '0;
        endcase
        if ((state == StBusy) && (cnt_q == CNTW'(1))) begin
            md_arm_d = 1'b1;
        end else if (!hz.StallE) begin
            // E advances this cycle, so the op in E is a new instruction next cycle.
            md_arm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            md_arm_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            md_arm_q <= md_arm_d;
        end
    end

    // Output logic. While a multi-cycle op holds E, the front end freezes and a
    // bubble goes to M; load-use and branch are ignored until E is released.
    always_comb begin
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.StallE    = 1'b0;
        hz.FlushD    = 1'b0;
        hz.FlushE    = 1'b0;
        hz.FlushM    = 1'b0;
        hz.MdBusy    = 1'b0;
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (reset) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end else begin
            hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
            hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
            hz.MdBusy    = md_busy;
            if (md_busy) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.FlushM = 1'b1;
            end else begin
                hz.StallF = lw_stall;
                hz.StallD = lw_stall;
                hz.FlushD = hz.PCSrcE;
                hz.FlushE = lw_stall || hz.PCSrcE;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] ld_cnt_q, br_cnt_q, md_cnt_q;
    logic              ld_evt, br_evt, md_evt;

    always_comb begin
        ld_evt = !md_busy && lw_stall;
        br_evt = !md_busy && hz.PCSrcE;
        md_evt = md_busy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt_q <= '0;
            br_cnt_q <= '0;
            md_cnt_q <= '0;
        end else begin
            if (ld_evt && (ld_cnt_q != '1)) ld_cnt_q <= ld_cnt_q + PERF_W'(1);
            if (br_evt && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + PERF_W'(1);
            if (md_evt && (md_cnt_q != '1)) md_cnt_q <= md_cnt_q + PERF_W'(1);
        end
    end

    assign LdStallCnt = ld_cnt_q;
    assign BrFlushCnt = br_cnt_q;
    assign MdStallCnt = md_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc (REGW=5, MD_LAT=4, PERF_W=4).
module tb_hazard_unit_mc;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REGW(5)) hif ();

`ifdef HAZARD_PERF_EN
    logic [3:0] ld_cnt, br_cnt, md_cnt;
`endif

    hazard_unit_mc #(
        .REGW   (5),
        .MD_LAT (4),
        .PERF_W (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
`ifdef HAZARD_PERF_EN
        ,
        .LdStallCnt (ld_cnt),
        .BrFlushCnt (br_cnt),
        .MdStallCnt (md_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0;
        hif.RdE = '0; hif.RdM = '0; hif.RdW = '0;
        hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; hif.ResultSrcE0 = 1'b0;
        hif.PCSrcE = 1'b0; hif.MdStartE = 1'b0;
    endtask

    // Packs {StallF,StallD,StallE,FlushD,FlushE,FlushM,MdBusy}.
    function automatic logic [6:0] ctl();
        return {hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE,
                hif.FlushM, hif.MdBusy};
    endfunction

    initial begin
        clear_inputs();
        reset = 1'b1;
        hif.MdStartE = 1'b1;
        hif.Rs1E = 5'd5; hif.RdM = 5'd5; hif.RegWriteM = 1'b1;
        @(negedge clk); #1;
        // Reset: only FlushD/FlushE high, MUL request ignored, forwards 00.
        chk("reset_ctl", 32'(ctl()), 32'b0001100);
        chk("reset_fwdA", 32'(hif.ForwardAE), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        // Forwarding: M priority over W.
        hif.Rs1E = 5'd5; hif.Rs2E = 5'd5; hif.RdM = 5'd5; hif.RdW = 5'd5;
        hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
        #1;
        chk("fwdA_m_prio", 32'(hif.ForwardAE), 32'd2);
        chk("fwdB_m_prio", 32'(hif.ForwardBE), 32'd2);
        chk("idle_ctl", 32'(ctl()), 32'b0000000);
        hif.RegWriteM = 1'b0; #1;
        chk("fwdA_w", 32'(hif.ForwardAE), 32'd1);
        hif.Rs1E = 5'd0; hif.RdM = 5'd0; hif.RdW = 5'd0; hif.RegWriteM = 1'b1; #1;
        chk("fwdA_x0", 32'(hif.ForwardAE), 32'd0);
        hif.Rs2E = 5'd6; hif.RdW = 5'd6; hif.RdM = 5'd5; #1;
        chk("fwdB_w_other", 32'(hif.ForwardBE), 32'd1);

        // Load-use.
        clear_inputs();
        hif.ResultSrcE0 = 1'b1; hif.RdE = 5'd7; hif.Rs2D = 5'd7; #1;
        chk("lw_stall", 32'(ctl()), 32'b1100100);
        hif.RdE = 5'd0; hif.Rs2D = 5'd0; #1;
        chk("lw_rd0", 32'(ctl()), 32'b0000000);
        // Branch + load-use same cycle.
        hif.RdE = 5'd7; hif.Rs1D = 5'd7; hif.PCSrcE = 1'b1; #1;
        chk("br_and_lw", 32'(ctl()), 32'b1101100);
        hif.ResultSrcE0 = 1'b0; #1;
        chk("br_only", 32'(ctl()), 32'b0001100);

        // MUL/DIV, MD_LAT=4: busy on launch + cnt 3,2,1, then E advances.
        @(negedge clk);
        clear_inputs();
        hif.MdStartE = 1'b1;
        hif.PCSrcE = 1'b1; hif.ResultSrcE0 = 1'b1; hif.RdE = 5'd3; hif.Rs1D = 5'd3;
        hif.Rs1E = 5'd9; hif.RdM = 5'd9; hif.RegWriteM = 1'b1;
        #1;
        chk("md_c0_masked", 32'(ctl()), 32'b1110011);
        chk("md_c0_fwd", 32'(hif.ForwardAE), 32'd2);
        hif.PCSrcE = 1'b0; hif.ResultSrcE0 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); #1;
            chk($sformatf("md_c%0d", i), 32'(ctl()), 32'b1110011);
        end
        hif.PCSrcE = 1'b1;
        @(negedge clk); #1;
        chk("md_c4_release", 32'(ctl()), 32'b0001100);
        hif.PCSrcE = 1'b0;
        // Back-to-back MUL: new op in E launches again.
        @(negedge clk); #1;
        chk("md_relaunch", 32'(hif.MdBusy), 32'd1);
        @(negedge clk); #1;
        chk("md_cnt3", 32'(hif.MdBusy), 32'd1);
        // Reset pulsed with cnt=2 aborts the op.
        @(negedge clk);
        reset = 1'b1; #1;
        chk("md_reset_out", 32'(ctl()), 32'b0001100);
        @(negedge clk);
        reset = 1'b0;
        hif.MdStartE = 1'b0; #1;
        chk("md_after_reset", 32'(ctl()), 32'b0000000);
        hif.MdStartE = 1'b1; #1;
        chk("md_launch_after_reset", 32'(hif.MdBusy), 32'd1);

`ifdef HAZARD_PERF_EN
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        hif.ResultSrcE0 = 1'b1; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
        for (int i = 0; i < 20; i++) @(negedge clk);
        clear_inputs();
        hif.PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        hif.PCSrcE = 1'b0;
        #1;
        chk("perf_ld_sat", 32'(ld_cnt), 32'd15);
        chk("perf_br", 32'(br_cnt), 32'd3);
        chk("perf_md", 32'(md_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
